// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: steps the PC, issues one instruction-memory
// request at a time and hands each fetched word to decode (valid/ready).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_start / i_halt            begin/resume fetching, halt at next fetch
//   i_redirect/_addr            branch/jump taken pulse and its target
//   i_pc                        current PC value (combinational PC output)
//   o_pc_input_en/o_pc_data     PC load enable and load value
//   o_pc_count_en               PC advance enable
//   o_imem_req/_addr            memory request and address
//   i_imem_ready                memory accepts the request this cycle
//   i_imem_rvalid/_rdata        memory read response
//   o_instr_valid/o_instr/_pc   instruction to decode and its address
//   i_instr_ready               decode accepts the instruction
//   o_halted                    sequencer is halted
module fetch_sequencer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_halt,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_addr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic                  o_pc_input_en,
  output logic                  o_pc_count_en,
  output logic [DATA_WIDTH-1:0] o_pc_data,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ready,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_instr_pc,
  input  logic                  i_instr_ready,
  output logic                  o_halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_HALT
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_redir_pend;
  logic [DATA_WIDTH-1:0] r_redir_addr;
  logic                  r_drop;
  logic                  r_halt_pend;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_instr_pc;

  logic   w_live;
  logic   w_acc;
  logic   w_halt;
  logic   w_rsp;
  logic   w_keep;
  state_t w_resume;

  assign w_live = (r_state != S_IDLE);
  assign w_acc  = (r_state == S_FETCH) && i_imem_ready;
  // A halt raised in the same cycle as a fetch boundary takes effect there.
  assign w_halt = r_halt_pend || i_halt;
  assign w_resume = w_halt ? S_HALT : S_FETCH;
  assign w_rsp  = (r_state == S_WAIT) && i_imem_rvalid;
  // A redirect coinciding with the response squashes that response too.
  assign w_keep = w_rsp && !r_drop && !i_redirect;

  assign o_instr    = r_instr;
  assign o_instr_pc = r_instr_pc;

  always_comb begin
    w_state_nxt   = r_state;
    o_imem_req    = 1'b0;
    o_imem_addr   = '0;
    o_pc_input_en = 1'b0;
    o_pc_count_en = 1'b0;
    o_pc_data     = '0;
    o_instr_valid = 1'b0;
    o_halted      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req  = 1'b1;
        o_imem_addr = i_pc;
        // Loading the target makes the PC present it on i_pc now.
        if (r_redir_pend) begin
          o_pc_input_en = 1'b1;
          o_pc_data     = r_redir_addr;
        end
        if (i_imem_ready) begin
          o_pc_count_en = 1'b1;
          w_state_nxt   = S_WAIT;
        end else if (w_halt) begin
          w_state_nxt = S_HALT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (r_drop || i_redirect) w_state_nxt = w_resume;
          else w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        o_instr_valid = 1'b1;
        if (i_instr_ready || i_redirect) w_state_nxt = w_resume;
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (i_start) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_redir_pend <= 1'b0;
      r_redir_addr <= '0;
      r_drop       <= 1'b0;
      r_halt_pend  <= 1'b0;
      r_instr      <= '0;
      r_instr_pc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_instr_pc   <= o_imem_addr;
        r_redir_pend <= 1'b0;
      end
      // Later assignment: a redirect in the accept cycle stays pending.
      if (i_redirect && w_live) begin
        r_redir_pend <= 1'b1;
        r_redir_addr <= i_redirect_addr;
      end
      if (w_keep) r_instr <= i_imem_rdata;
      if (w_rsp) begin
        r_drop <= 1'b0;
      end else if (i_redirect && (w_acc || r_state == S_WAIT)) begin
        r_drop <= 1'b1;
      end
      if (r_state == S_HALT && i_start) begin
        r_halt_pend <= i_halt;
      end else if (i_halt && w_live) begin
        r_halt_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC and memory models, in-order stream
// scoreboard, directed scenarios followed by a randomized run.
module tb_fetch_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_halt = 1'b0;
  logic         i_redirect = 1'b0;
  logic [W-1:0] i_redirect_addr = '0;
  logic [W-1:0] i_pc;
  logic         o_pc_input_en;
  logic         o_pc_count_en;
  logic [W-1:0] o_pc_data;
  logic         o_imem_req;
  logic [W-1:0] o_imem_addr;
  logic         i_imem_ready = 1'b0;
  logic         i_imem_rvalid = 1'b0;
  logic [W-1:0] i_imem_rdata = '0;
  logic         o_instr_valid;
  logic [W-1:0] o_instr;
  logic [W-1:0] o_instr_pc;
  logic         i_instr_ready = 1'b0;
  logic         o_halted;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_halt(i_halt),
    .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
    .i_pc(i_pc),
    .o_pc_input_en(o_pc_input_en), .o_pc_count_en(o_pc_count_en),
    .o_pc_data(o_pc_data),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata(i_imem_rdata),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr),
    .o_instr_pc(o_instr_pc), .i_instr_ready(i_instr_ready),
    .o_halted(o_halted)
  );

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Program counter with a combinational output (load value bypasses).
  logic [W-1:0] pc_q;
  logic [W-1:0] pc_o;
  assign pc_o = o_pc_input_en ? o_pc_data : pc_q;
  assign i_pc = pc_o;
  always @(posedge clk) begin
    if (rst) pc_q <= '0;
    else if (o_pc_count_en) pc_q <= pc_o + 1'b1;
    else if (o_pc_input_en) pc_q <= o_pc_data;
  end

  // Instruction memory: one response per accepted request after lat cycles.
  int           lat_cfg = 1;
  bit           lat_rand = 0;
  bit           rdy_rand = 0;
  bit           rdy_force = 1;
  logic         m_pend = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_addr = '0;
  logic         s_acc = 1'b0;
  logic [W-1:0] s_addr = '0;

  always @(posedge clk) begin
    #1;
    i_imem_rvalid = 1'b0;
    if (s_acc) begin
      m_pend = 1'b1;
      m_addr = s_addr;
      m_cnt = lat_rand ? int'($urandom_range(1, 3)) : lat_cfg;
    end
    if (m_pend) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata = mem_word(m_addr);
        m_pend = 1'b0;
      end
    end
    i_imem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor / scoreboard: delivered stream must be the architectural
  // sequence (sequential, restarting at every redirect target).
  bit           started = 0;
  logic [W-1:0] exp_pc = '0;
  int           n_deliv = 0;
  int           n_acc = 0;
  int           n_cnt = 0;
  int           n_inen = 0;
  logic [W-1:0] last_pc = '0;
  bit           pv = 0;
  bit           psq = 0;
  logic [W-1:0] pinstr = '0;
  logic [W-1:0] ppc = '0;

  always @(negedge clk) begin
    s_acc = 1'b0;
    if (rst) begin
      started = 0;
      exp_pc = '0;
      pv = 0;
      psq = 0;
    end else begin
      if (pv) begin
        chk1("hold_valid", o_instr_valid, 1'b1);
        chkw("hold_instr", o_instr, pinstr);
        chkw("hold_pc", o_instr_pc, ppc);
      end
      if (psq) chk1("squash", o_instr_valid, 1'b0);
      chk1("cnt_en", o_pc_count_en, o_imem_req & i_imem_ready);
      chk1("inen_req", o_pc_input_en & ~o_imem_req, 1'b0);
      chk1("halt_req", o_halted & o_imem_req, 1'b0);
      chk1("one_out", o_imem_req & (m_pend | i_imem_rvalid), 1'b0);
      if (o_imem_req) chkw("req_addr", o_imem_addr, pc_o);
      if (!started) begin
        chk1("idle_valid", o_instr_valid, 1'b0);
        chk1("idle_req", o_imem_req, 1'b0);
        chk1("idle_halted", o_halted, 1'b0);
      end
      if (o_instr_valid && i_instr_ready) begin
        chkw("deliv_pc", o_instr_pc, exp_pc);
        chkw("deliv_instr", o_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 1'b1;
        n_deliv++;
        last_pc = o_instr_pc;
      end
      if (o_imem_req && i_imem_ready) begin
        s_acc = 1'b1;
        s_addr = o_imem_addr;
        n_acc++;
      end
      if (o_pc_count_en) n_cnt++;
      if (o_pc_input_en) n_inen++;
      if (i_redirect && started) exp_pc = i_redirect_addr;
      pv = o_instr_valid && !i_instr_ready && !i_redirect;
      psq = o_instr_valid && !i_instr_ready && i_redirect;
      pinstr = o_instr;
      ppc = o_instr_pc;
      if (i_start) started = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic next_acc(output logic [W-1:0] a, output logic ie);
    bit found = 0;
    a = '0;
    ie = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (o_imem_req && i_imem_ready) begin
        found = 1;
        a = o_imem_addr;
        ie = o_pc_input_en;
      end
    end
    chk1("acc_timeout", found, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input bit want_halt, input string tag);
    bit found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (want_halt ? o_halted : o_instr_valid) found = 1;
    end
    chk1(tag, found, 1'b1);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ie;
  int           a0;
  int           c0;
  int           d0;

  initial begin
    // Reset state
    step(3);
    rst = 1'b0;
    chk1("rst_req", o_imem_req, 1'b0);
    chk1("rst_valid", o_instr_valid, 1'b0);
    chk1("rst_halted", o_halted, 1'b0);
    chk1("rst_cnt", o_pc_count_en, 1'b0);
    chk1("rst_inen", o_pc_input_en, 1'b0);
    chkw("rst_instr", o_instr, '0);
    chkw("rst_ipc", o_instr_pc, '0);

    // Sequential fetch, zero-wait memory, decode always ready
    i_instr_ready = 1'b1;
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    step(12);
    chki("seq_deliv", n_deliv, 4);
    chki("seq_acc", n_acc, 4);
    chki("seq_cnt", n_cnt, 4);
    chki("seq_inen", n_inen, 0);
    chkw("seq_last", last_pc, 16'h0003);

    // Backpressure in OUT
    i_instr_ready = 1'b0;
    wait_for(1'b0, "bp_valid_timeout");
    a0 = n_acc;
    c0 = n_cnt;
    step(5);
    chk1("bp_valid", o_instr_valid, 1'b1);
    chkw("bp_pc", o_instr_pc, 16'h0004);
    chkw("bp_instr", o_instr, mem_word(16'h0004));
    chki("bp_acc", n_acc, a0);
    chki("bp_cnt", n_cnt, c0);
    i_instr_ready = 1'b1;
    next_acc(a, ie);
    chkw("bp_next", a, 16'h0005);

    // Redirect while waiting on memory
    lat_cfg = 3;
    next_acc(a, ie);
    chkw("rw_addr", a, 16'h0006);
    d0 = n_deliv;
    i_redirect = 1'b1;
    i_redirect_addr = 16'h0040;
    step(1);
    i_redirect = 1'b0;
    next_acc(a, ie);
    chkw("rw_tgt", a, 16'h0040);
    chk1("rw_tgt_ie", ie, 1'b1);
    chki("rw_nodeliv", n_deliv, d0);
    next_acc(a, ie);
    chkw("rw_seq", a, 16'h0041);
    chk1("rw_seq_ie", ie, 1'b0);

    // Redirect in OUT without and with decode ready
    lat_cfg = 1;
    i_instr_ready = 1'b0;
    wait_for(1'b0, "ro_valid_timeout");
    chkw("ro_pc", o_instr_pc, 16'h0041);
    d0 = n_deliv;
    i_redirect = 1'b1;
    i_redirect_addr = 16'h0100;
    step(1);
    i_redirect = 1'b0;
    chk1("ro_squash", o_instr_valid, 1'b0);
    next_acc(a, ie);
    chkw("ro_tgt", a, 16'h0100);
    chk1("ro_tgt_ie", ie, 1'b1);
    chki("ro_nodeliv", n_deliv, d0);
    wait_for(1'b0, "ro2_valid_timeout");
    chkw("ro2_pc", o_instr_pc, 16'h0100);
    i_redirect = 1'b1;
    i_redirect_addr = 16'h0200;
    i_instr_ready = 1'b1;
    step(1);
    i_redirect = 1'b0;
    chki("ro2_deliv", n_deliv, d0 + 1);
    chkw("ro2_last", last_pc, 16'h0100);
    next_acc(a, ie);
    chkw("ro2_tgt", a, 16'h0200);

    // Halt during WAIT, then restart
    lat_cfg = 3;
    next_acc(a, ie);
    d0 = n_deliv;
    i_halt = 1'b1;
    step(1);
    i_halt = 1'b0;
    wait_for(1'b1, "halt_timeout");
    chki("halt_deliv", n_deliv, d0 + 1);
    chkw("halt_last", last_pc, a);
    a0 = n_acc;
    step(10);
    chki("halt_noreq", n_acc, a0);
    chk1("halt_flag", o_halted, 1'b1);
    chk1("halt_req", o_imem_req, 1'b0);
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    chk1("halt_clr", o_halted, 1'b0);
    b = a + 1'b1;
    next_acc(a, ie);
    chkw("halt_resume", a, b);

    // Reset while a request is outstanding
    lat_cfg = 5;
    next_acc(a, ie);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk1("mr_req", o_imem_req, 1'b0);
    chk1("mr_valid", o_instr_valid, 1'b0);
    chk1("mr_halted", o_halted, 1'b0);
    chk1("mr_cnt", o_pc_count_en, 1'b0);
    chkw("mr_instr", o_instr, '0);
    chkw("mr_ipc", o_instr_pc, '0);
    step(8);
    chk1("mr_stray", o_instr_valid, 1'b0);
    lat_cfg = 1;
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    next_acc(a, ie);
    chkw("mr_restart", a, 16'h0000);
    chk1("mr_restart_ie", ie, 1'b0);

    // Randomized traffic against the stream scoreboard
    lat_rand = 1;
    rdy_rand = 1;
    d0 = n_deliv;
    for (int k = 0; k < 2000; k++) begin
      i_instr_ready = 1'($urandom_range(0, 1));
      i_redirect = ($urandom_range(0, 15) == 0);
      i_redirect_addr = 16'($urandom);
      i_halt = ($urandom_range(0, 63) == 0);
      i_start = ($urandom_range(0, 7) == 0);
      step(1);
    end
    i_redirect = 1'b0;
    i_halt = 1'b0;
    i_start = 1'b0;
    chk1("rand_progress", (n_deliv - d0) > 50, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
